// File: rtl/num_entry_pkg.sv
// rtl/num_entry_pkg.sv - shared widths, FSM states and button indices for the digit entry front end
package num_entry_pkg;

  localparam int DIGIT_W       = 4;
  localparam int NUM_DIGITS    = 4;
  localparam int MAX_DIGIT_DEF = 9;
  localparam int NUM_BTNS      = 5;

  // Lower index wins when several press events land in the same cycle
  localparam int BTN_C = 0;
  localparam int BTN_U = 1;
  localparam int BTN_D = 2;
  localparam int BTN_L = 3;
  localparam int BTN_R = 4;

  typedef logic [DIGIT_W-1:0] digit_t;

  typedef enum logic {
    ST_EDIT   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

endpackage

// File: rtl/num_entry_if.sv
// rtl/num_entry_if.sv - push-button inputs and entered-digit outputs of the digit entry block
interface num_entry_if;
  import num_entry_pkg::*;

  logic   btn_u;
  logic   btn_d;
  logic   btn_l;
  logic   btn_r;
  logic   btn_c;
  digit_t nums_0;
  digit_t nums_1;
  digit_t nums_2;
  digit_t nums_3;
  logic [1:0] cursor;
  logic   locked;
  logic   start_pulse;

  modport master (
    output btn_u, btn_d, btn_l, btn_r, btn_c,
    input  nums_0, nums_1, nums_2, nums_3, cursor, locked, start_pulse
  );

  modport slave (
    input  btn_u, btn_d, btn_l, btn_r, btn_c,
    output nums_0, nums_1, nums_2, nums_3, cursor, locked, start_pulse
  );
endinterface

// File: rtl/num_entry_btn_debounce.sv
// rtl/num_entry_btn_debounce.sv - button synchroniser, debouncer and rising-edge press detector
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic press
);

  localparam int CW = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES);

  logic          sync_1;
  logic          sync_2;
  logic          level_d;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_1  <= 1'b0;
      sync_2  <= 1'b0;
      level   <= 1'b0;
      level_d <= 1'b0;
      press   <= 1'b0;
      cnt     <= '0;
    end else begin
      sync_1  <= raw;
      sync_2  <= sync_1;
      level_d <= level;
      press   <= level & ~level_d;
      // Any sample agreeing with the accepted state restarts the stability window
      if (sync_2 == level) begin
        cnt <= '0;
      end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        level <= sync_2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/num_entry.sv
// rtl/num_entry.sv - four-digit entry with cursor, lock/start control; NUM_ENTRY_REPEAT_EN adds U/D auto-repeat
module num_entry
  import num_entry_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int MAX_DIGIT       = MAX_DIGIT_DEF
`ifdef NUM_ENTRY_REPEAT_EN
  ,
  parameter int REPEAT_DELAY    = 50_000_000,
  parameter int REPEAT_PERIOD   = 10_000_000
`endif
) (
  input  logic        clk,
  input  logic        rst,
  num_entry_if.slave  bus
);

  logic [NUM_BTNS-1:0] raw;
  logic [NUM_BTNS-1:0] level;
  logic [NUM_BTNS-1:0] press;
  logic [NUM_BTNS-1:0] ev;

  assign raw = {bus.btn_r, bus.btn_l, bus.btn_d, bus.btn_u, bus.btn_c};

  for (genvar b = 0; b < NUM_BTNS; b++) begin : g_btn
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn (
      .clk   (clk),
      .rst   (rst),
      .raw   (raw[b]),
      .level (level[b]),
      .press (press[b])
    );
  end

  state_t     state;
  state_t     state_next;
  digit_t     nums      [NUM_DIGITS];
  digit_t     nums_next [NUM_DIGITS];
  logic [1:0] cursor;
  logic [1:0] cursor_next;
  logic       start_pulse;
  logic       start_next;

`ifdef NUM_ENTRY_REPEAT_EN
  localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW      = $clog2(REP_MAX + 1);

  // Slot 0 tracks U, slot 1 tracks D; count is cycles since the last action, 0 = idle
  logic [RW-1:0] rep_cnt   [2];
  logic [1:0]    rep_phase;
  logic [1:0]    rep_ev;

  always_comb begin
    rep_ev = '0;
    for (int i = 0; i < 2; i++) begin
      rep_ev[i] = (rep_cnt[i] != '0) &&
                  (rep_phase[i] ? (rep_cnt[i] == RW'(REPEAT_PERIOD))
                                : (rep_cnt[i] == RW'(REPEAT_DELAY)));
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst || state != ST_EDIT || !level[BTN_U + i]) begin
        rep_cnt[i]   <= '0;
        rep_phase[i] <= 1'b0;
      end else if (press[BTN_U + i]) begin
        rep_cnt[i]   <= RW'(1);
        rep_phase[i] <= 1'b0;
      end else if (rep_ev[i]) begin
        rep_cnt[i]   <= RW'(1);
        rep_phase[i] <= 1'b1;
      end else if (rep_cnt[i] != '0) begin
        rep_cnt[i]   <= rep_cnt[i] + 1'b1;
      end
    end
  end

  assign ev = press | {2'b00, rep_ev, 1'b0};
`else
  assign ev = press;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_EDIT;
      nums        <= '{default: '0};
      cursor      <= 2'd3;
      start_pulse <= 1'b0;
    end else begin
      state       <= state_next;
      nums        <= nums_next;
      cursor      <= cursor_next;
      start_pulse <= start_next;
    end
  end

  always_comb begin
    state_next  = state;
    nums_next   = nums;
    cursor_next = cursor;
    start_next  = 1'b0;
    case (state)
      ST_EDIT: begin
        if (ev[BTN_C]) begin
          state_next = ST_LOCKED;
          start_next = 1'b1;
        end else if (ev[BTN_U]) begin
          nums_next[cursor] = (nums[cursor] == DIGIT_W'(MAX_DIGIT)) ? '0 : nums[cursor] + 1'b1;
        end else if (ev[BTN_D]) begin
          nums_next[cursor] = (nums[cursor] == '0) ? DIGIT_W'(MAX_DIGIT) : nums[cursor] - 1'b1;
        end else if (ev[BTN_L]) begin
          cursor_next = cursor + 2'd1;
        end else if (ev[BTN_R]) begin
          cursor_next = cursor - 2'd1;
        end
      end
      ST_LOCKED: begin
        if (ev[BTN_C]) begin
          state_next = ST_EDIT;
        end
      end
      default: state_next = ST_EDIT;
    endcase
  end

  assign bus.nums_0      = nums[0];
  assign bus.nums_1      = nums[1];
  assign bus.nums_2      = nums[2];
  assign bus.nums_3      = nums[3];
  assign bus.cursor      = cursor;
  assign bus.locked      = (state == ST_LOCKED);
  assign bus.start_pulse = start_pulse;

endmodule

// File: tb/tb_num_entry.sv
// tb/tb_num_entry.sv - self-checking bench for num_entry with a cycle model and directed button scenarios
module tb_num_entry;

  localparam int N  = 4;
  localparam int RD = 20;
  localparam int RP = 8;
  localparam int C  = 0;
  localparam int U  = 1;
  localparam int D  = 2;
  localparam int L  = 3;
  localparam int R  = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] btn = '0;

  int tests = 0;
  int fails = 0;
  int start_count = 0;

  always #5 clk = ~clk;

  num_entry_if ifc ();

  assign ifc.btn_c = btn[C];
  assign ifc.btn_u = btn[U];
  assign ifc.btn_d = btn[D];
  assign ifc.btn_l = btn[L];
  assign ifc.btn_r = btn[R];

  num_entry #(
    .DEBOUNCE_CYCLES (N),
    .MAX_DIGIT       (9)
`ifdef NUM_ENTRY_REPEAT_EN
    ,
    .REPEAT_DELAY    (RD),
    .REPEAT_PERIOD   (RP)
`endif
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  // Model: a button is accepted once N consecutive synchronised samples disagree with the
  // accepted value; a press acts on the outputs two edges after acceptance.
  int  hist   [5][8];
  bit  mlvl   [5];
  bit  mlvl_d [5];
  bit  mpress [5];
  int  mnums  [4];
  int  mcur;
  bit  mlock;
  bit  mstart;
  int  mage   [2];
  bit  mvalid = 1'b0;

  always @(posedge clk) begin : model
    bit ev [5];
    bit all_flip;
    if (rst) begin
      for (int b = 0; b < 5; b++) begin
        for (int j = 0; j < 8; j++) hist[b][j] = 0;
        mlvl[b] = 0; mlvl_d[b] = 0; mpress[b] = 0;
      end
      for (int i = 0; i < 4; i++) mnums[i] = 0;
      mcur = 3; mlock = 0; mstart = 0;
      mage[0] = 0; mage[1] = 0;
      mvalid = 1'b1;
    end else begin
      for (int b = 0; b < 5; b++) ev[b] = mpress[b];
`ifdef NUM_ENTRY_REPEAT_EN
      for (int i = 0; i < 2; i++) begin
        if (mage[i] > 0 && (mage[i] == RD || (mage[i] > RD && (mage[i] - RD) % RP == 0)))
          ev[U + i] = 1;
      end
`endif
      for (int i = 0; i < 2; i++) begin
        if (mlock || !mlvl[U + i]) mage[i] = 0;
        else if (mpress[U + i])    mage[i] = 1;
        else if (mage[i] > 0)      mage[i] = mage[i] + 1;
      end
      mstart = 0;
      if (!mlock) begin
        if (ev[C])      begin mlock = 1; mstart = 1; end
        else if (ev[U]) mnums[mcur] = (mnums[mcur] == 9) ? 0 : mnums[mcur] + 1;
        else if (ev[D]) mnums[mcur] = (mnums[mcur] == 0) ? 9 : mnums[mcur] - 1;
        else if (ev[L]) mcur = (mcur == 3) ? 0 : mcur + 1;
        else if (ev[R]) mcur = (mcur == 0) ? 3 : mcur - 1;
      end else if (ev[C]) begin
        mlock = 0;
      end
      for (int b = 0; b < 5; b++) begin
        mpress[b] = mlvl[b] && !mlvl_d[b];
        mlvl_d[b] = mlvl[b];
        all_flip = 1;
        for (int j = 1; j <= N; j++) if ((hist[b][j] != 0) == mlvl[b]) all_flip = 0;
        if (all_flip) mlvl[b] = !mlvl[b];
        for (int j = 7; j > 0; j--) hist[b][j] = hist[b][j-1];
        hist[b][0] = btn[b] ? 1 : 0;
      end
    end
  end

  always @(negedge clk) begin : compare
    logic [15:0] dn;
    logic [15:0] mn;
    if (mvalid) begin
      dn = {ifc.nums_3, ifc.nums_2, ifc.nums_1, ifc.nums_0};
      mn = {4'(mnums[3]), 4'(mnums[2]), 4'(mnums[1]), 4'(mnums[0])};
      if (ifc.start_pulse === 1'b1) start_count++;
      tests++;
      if (dn !== mn || ifc.cursor !== 2'(mcur) || ifc.locked !== mlock || ifc.start_pulse !== mstart) begin
        fails++;
        $display("FAIL cycle_model t=%0t got nums=%h cur=%0d lk=%0b sp=%0b want nums=%h cur=%0d lk=%0b sp=%0b",
                 $time, dn, ifc.cursor, ifc.locked, ifc.start_pulse, mn, mcur, mlock, mstart);
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic tap(input int b);
    @(negedge clk);
    btn[b] = 1'b1;
    repeat (6) @(negedge clk);
    btn[b] = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  int lat;
  int sc0;

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Idle after reset
    repeat (50) @(negedge clk);
    check("idle_nums", int'({ifc.nums_3, ifc.nums_2, ifc.nums_1, ifc.nums_0}), 0);
    check("idle_cursor", int'(ifc.cursor), 3);
    check("idle_locked", int'(ifc.locked), 0);
    check("idle_start", start_count, 0);

    // Bounced U press: one action, visible 8 edges after the stable edge
    btn[U] = 1'b1; @(negedge clk);
    btn[U] = 1'b0; @(negedge clk);
    btn[U] = 1'b1; @(negedge clk);
    btn[U] = 1'b0; @(negedge clk);
    btn[U] = 1'b1;
    lat = -1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (lat < 0 && ifc.nums_3 != 4'd0) lat = k;
    end
    btn[U] = 1'b0;
    repeat (12) @(negedge clk);
    check("bounce_latency", lat, 8);
    check("bounce_nums3", int'(ifc.nums_3), 1);

    // Cursor wrap and digit wrap
    tap(R); tap(R); tap(R);
    check("cursor_0", int'(ifc.cursor), 0);
    tap(D);
    check("dec_wrap", int'(ifc.nums_0), 9);
    tap(U);
    check("inc_wrap", int'(ifc.nums_0), 0);
    tap(R);
    check("cursor_wrap", int'(ifc.cursor), 3);

    // Enter 7,3,9,1 then lock/unlock
    repeat (6) tap(U);
    tap(R); repeat (3) tap(U);
    tap(R); tap(D);
    tap(R); tap(U);
    check("entry", int'({ifc.nums_3, ifc.nums_2, ifc.nums_1, ifc.nums_0}), 16'h7391);
    sc0 = start_count;
    tap(C);
    check("start_once", start_count - sc0, 1);
    check("locked_on", int'(ifc.locked), 1);
    tap(U); tap(L);
    check("locked_nums", int'({ifc.nums_3, ifc.nums_2, ifc.nums_1, ifc.nums_0}), 16'h7391);
    check("locked_cursor", int'(ifc.cursor), 0);
    tap(C);
    check("unlocked", int'(ifc.locked), 0);
    check("retained", int'({ifc.nums_3, ifc.nums_2, ifc.nums_1, ifc.nums_0}), 16'h7391);

    // C and U together: C wins; then reset while locked
    tap(L);
    @(negedge clk);
    btn[C] = 1'b1; btn[U] = 1'b1;
    repeat (6) @(negedge clk);
    btn[C] = 1'b0; btn[U] = 1'b0;
    repeat (8) @(negedge clk);
    check("prio_locked", int'(ifc.locked), 1);
    check("prio_nums3", int'(ifc.nums_3), 7);
    rst = 1'b1;
    @(negedge clk);
    check("rst_nums", int'({ifc.nums_3, ifc.nums_2, ifc.nums_1, ifc.nums_0}), 0);
    check("rst_cursor", int'(ifc.cursor), 3);
    check("rst_locked", int'(ifc.locked), 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // Long hold of U
    btn[U] = 1'b1;
    repeat (42) @(negedge clk);
    btn[U] = 1'b0;
    repeat (12) @(negedge clk);
`ifdef NUM_ENTRY_REPEAT_EN
    check("hold_repeat", int'(ifc.nums_3), 4);
`else
    check("hold_single", int'(ifc.nums_3), 1);
`endif

    repeat (5) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
